// File: rtl/mem_arbiter.sv
// mem_arbiter: NCH-channel memory-port arbiter and byte serialiser onto an
// 8-bit RAM/IO bus. Fixed or round-robin priority. Transfers are 1, 2 or 4
// bytes. Read addresses are pipelined, so a read costs L+1 bus cycles.
// The whole block pauses while rdy_in is low.
module mem_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter bit          RR_MODE = 1'b0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH-1:0]    we_i,
    input  logic [2*NCH-1:0]  len_i,
    input  logic [32*NCH-1:0] addr_i,
    input  logic [32*NCH-1:0] wdata_i,
    output logic [NCH-1:0]    done_o,
    output logic [31:0]       rdata_o,
    output logic              busy_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_TAIL
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  ch_q;
    logic [CW-1:0]  rr_ptr_q;
    logic [CW-1:0]  rr_next;
    logic [CW-1:0]  grant_idx;
    logic           grant_vld;
    logic [NCH-1:0] elig;
    logic           we_q;
    logic [1:0]     last_q;
    logic [1:0]     k_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    cap_q;
    logic [31:0]    cap_d;
    logic           cap_vld_q;
    logic [1:0]     cap_idx_q;
    logic [1:0]     grant_len;
    logic           last_byte;

    assign last_byte = (k_q == last_q);
    assign grant_len = len_i[2*grant_idx +: 2];
    assign rr_next   = (32'(ch_q) == NCH - 1) ? '0 : ch_q + 1'b1;

    // Pick the winning channel; a channel in its own done cycle is not eligible.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        elig      = req_i & ~done_o;
        for (int unsigned off = 0; off < NCH; off++) begin
            if (RR_MODE) begin
                idx = (32'(rr_ptr_q) + off) % NCH;
            end else begin
                idx = off;
            end
            if (!grant_vld && elig[CW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld) state_d = S_XFER;
            S_XFER:  if (last_byte) state_d = we_q ? S_IDLE : S_TAIL;
            S_TAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive: address/data only in XFER; write strobe drops while paused.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        busy_o   = (state_q != S_IDLE);
        if (state_q == S_XFER) begin
            mem_a = addr_q + 32'(k_q);
            if (we_q) begin
                mem_dout = 8'(wdata_q >> {k_q, 3'b000});
                mem_wr   = rdy_in;
            end
        end
    end

    // Merge the pending read byte into the capture word.
    always_comb begin
        cap_d = cap_q;
        if (cap_vld_q) begin
            case (cap_idx_q)
                2'd0: cap_d[7:0]   = mem_din;
                2'd1: cap_d[15:8]  = mem_din;
                2'd2: cap_d[23:16] = mem_din;
                default: cap_d[31:24] = mem_din;
            endcase
        end
    end

    // Sequencer registers. Read capture runs even when paused, so a byte
    // addressed in the last active cycle is not lost.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            done_o    <= '0;
            rdata_o   <= '0;
            rr_ptr_q  <= '0;
            ch_q      <= '0;
            we_q      <= 1'b0;
            last_q    <= '0;
            k_q       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            cap_vld_q <= 1'b0;
            cap_q     <= cap_d;
            if (rdy_in) begin
                state_q <= state_d;
                done_o  <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (grant_vld) begin
                            ch_q    <= grant_idx;
                            we_q    <= we_i[grant_idx];
                            last_q  <= {grant_len[1], grant_len[1] | grant_len[0]};
                            addr_q  <= addr_i[32*grant_idx +: 32];
                            wdata_q <= wdata_i[32*grant_idx +: 32];
                            k_q     <= '0;
                            cap_q   <= '0;
                        end
                    end
                    S_XFER: begin
                        k_q <= k_q + 2'd1;
                        if (!we_q) begin
                            cap_vld_q <= 1'b1;
                            cap_idx_q <= k_q;
                        end
                        if (last_byte && we_q) begin
                            done_o[ch_q] <= 1'b1;
                            rr_ptr_q     <= rr_next;
                        end
                    end
                    S_TAIL: begin
                        done_o[ch_q] <= 1'b1;
                        rdata_o      <= cap_d;
                        rr_ptr_q     <= rr_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-priority instance for the main
// sequences, round-robin instance for the alternation sequence.
module tb_mem_arbiter;

    localparam int unsigned NCH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [NCH-1:0]    req_f, req_r, we;
    logic [2*NCH-1:0]  len;
    logic [32*NCH-1:0] addr, wdata;
    logic [NCH-1:0]    done_f, done_r;
    logic [31:0]       rdata_f, rdata_r;
    logic              busy_f, busy_r;
    logic [7:0]        mem_din_f, mem_din_r;
    logic [7:0]        mem_dout_f, mem_dout_r;
    logic [31:0]       mem_a_f, mem_a_r;
    logic              mem_wr_f, mem_wr_r;

    logic [7:0]  ram [logic [31:0]];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned io_hits  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NCH(NCH), .RR_MODE(1'b0)) u_fix (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .req_i(req_f), .we_i(we), .len_i(len), .addr_i(addr), .wdata_i(wdata),
        .done_o(done_f), .rdata_o(rdata_f), .busy_o(busy_f),
        .mem_din(mem_din_f), .mem_dout(mem_dout_f), .mem_a(mem_a_f), .mem_wr(mem_wr_f)
    );

    mem_arbiter #(.NCH(NCH), .RR_MODE(1'b1)) u_rr (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .req_i(req_r), .we_i(we), .len_i(len), .addr_i(addr), .wdata_i(wdata),
        .done_o(done_r), .rdata_o(rdata_r), .busy_o(busy_r),
        .mem_din(mem_din_r), .mem_dout(mem_dout_r), .mem_a(mem_a_r), .mem_wr(mem_wr_r)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    // RAM model: read data valid the cycle after its address
    always @(posedge clk) begin
        mem_din_f <= ram_rd(mem_a_f);
        mem_din_r <= ram_rd(mem_a_r);
    end

    // Count bus cycles presenting the IO address
    always @(negedge clk) begin
        if (mem_a_f == 32'h0003_0000) io_hits++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int unsigned c, input logic w, input logic [1:0] l,
                          input logic [31:0] a, input logic [31:0] d);
        we[c]            = w;
        len[2*c +: 2]    = l;
        addr[32*c +: 32] = a;
        wdata[32*c +: 32] = d;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; req_f = '0; req_r = '0;
        we = '0; len = '0; addr = '0; wdata = '0;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22;
        ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h200] = 8'hA1; ram[32'h201] = 8'hB2;
        ram[32'h202] = 8'hC3; ram[32'h203] = 8'hD4;
        ram[32'h3_0000] = 8'h5A;

        // Reset state
        tick(2);
        check("rst_done",  32'(done_f), 32'h0);
        check("rst_rdata", rdata_f, 32'h0);
        check("rst_busy",  32'(busy_f), 32'h0);
        check("rst_mem_a", mem_a_f, 32'h0);
        check("rst_wr",    32'(mem_wr_f), 32'h0);
        check("rst_dout",  32'(mem_dout_f), 32'h0);
        rst = 1'b0;

        // ch0 4-byte read at 0x100
        set_ch(0, 1'b0, 2'd3, 32'h100, 32'h0);
        req_f = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd4_addr", mem_a_f, 32'h100 + 32'(i));
            check("rd4_wr", 32'(mem_wr_f), 32'h0);
        end
        tick();
        check("rd4_tail_busy", 32'(busy_f), 32'h1);
        check("rd4_tail_done", 32'(done_f), 32'h0);
        check("rd4_tail_a", mem_a_f, 32'h0);
        tick();
        check("rd4_done", 32'(done_f), 32'h1);
        check("rd4_data", rdata_f, 32'h4433_2211);
        req_f = 2'b00;
        tick();
        check("rd4_pulse", 32'(done_f), 32'h0);
        check("rd4_hold", rdata_f, 32'h4433_2211);

        // ch1 2-byte write across a 64K boundary
        set_ch(1, 1'b1, 2'd1, 32'h0001_FFFF, 32'h0000_BEEF);
        req_f = 2'b10;
        tick();
        check("wr2_a0", mem_a_f, 32'h0001_FFFF);
        check("wr2_d0", 32'(mem_dout_f), 32'hEF);
        check("wr2_w0", 32'(mem_wr_f), 32'h1);
        tick();
        check("wr2_a1", mem_a_f, 32'h0002_0000);
        check("wr2_d1", 32'(mem_dout_f), 32'hBE);
        check("wr2_w1", 32'(mem_wr_f), 32'h1);
        tick();
        check("wr2_done", 32'(done_f), 32'h2);
        check("wr2_wr_off", 32'(mem_wr_f), 32'h0);
        check("wr2_rdata", rdata_f, 32'h4433_2211);
        req_f = 2'b00;
        tick();

        // 4-byte read with a 3-cycle pause after byte 1 is issued
        set_ch(0, 1'b0, 2'd3, 32'h200, 32'h0);
        req_f = 2'b01;
        tick();
        check("pz_a0", mem_a_f, 32'h200);
        tick();
        check("pz_a1", mem_a_f, 32'h201);
        tick();
        rdy = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (p != 0) tick();
            check("pz_hold_a", mem_a_f, 32'h202);
            check("pz_hold_busy", 32'(busy_f), 32'h1);
            check("pz_hold_wr", 32'(mem_wr_f), 32'h0);
        end
        tick();
        rdy = 1'b1;
        check("pz_a2", mem_a_f, 32'h202);
        tick();
        check("pz_a3", mem_a_f, 32'h203);
        tick();
        check("pz_tail_done", 32'(done_f), 32'h0);
        tick();
        check("pz_done", 32'(done_f), 32'h1);
        check("pz_data", rdata_f, 32'hD4C3_B2A1);
        req_f = 2'b00;
        tick();

        // 1-byte IO read at 0x30000
        io_hits = 0;
        set_ch(0, 1'b0, 2'd0, 32'h0003_0000, 32'h0);
        req_f = 2'b01;
        tick();
        check("io_a", mem_a_f, 32'h0003_0000);
        tick();
        check("io_tail_a", mem_a_f, 32'h0);
        tick();
        check("io_done", 32'(done_f), 32'h1);
        check("io_data", rdata_f, 32'h0000_005A);
        req_f = 2'b00;
        tick(2);
        check("io_hits", io_hits, 32'd1);

        // Fixed priority: simultaneous requests, ch0 first, ch1 granted in done cycle
        set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
        set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0);
        req_f = 2'b11;
        tick();
        check("fx_first_a", mem_a_f, 32'h100);
        tick(2);
        check("fx_done0", 32'(done_f), 32'h1);
        check("fx_data0", rdata_f, 32'h11);
        req_f = 2'b10;
        tick();
        check("fx_second_a", mem_a_f, 32'h101);
        tick(2);
        check("fx_done1", 32'(done_f), 32'h2);
        check("fx_data1", rdata_f, 32'h22);
        req_f = 2'b00;
        tick();

        // Reset in mid 4-byte write, with a pause probe first
        set_ch(0, 1'b1, 2'd3, 32'h400, 32'hCAFE_F00D);
        req_f = 2'b01;
        tick();
        check("rw_a0", mem_a_f, 32'h400);
        check("rw_d0", 32'(mem_dout_f), 32'h0D);
        check("rw_w0", 32'(mem_wr_f), 32'h1);
        tick();
        check("rw_d1", 32'(mem_dout_f), 32'hF0);
        rdy = 1'b0;
        #1;
        check("rw_pause_wr", 32'(mem_wr_f), 32'h0);
        check("rw_pause_a", mem_a_f, 32'h401);
        rdy = 1'b1;
        #1;
        check("rw_resume_wr", 32'(mem_wr_f), 32'h1);
        rst = 1'b1;
        req_f = 2'b00;
        tick();
        check("rw_rst_wr", 32'(mem_wr_f), 32'h0);
        check("rw_rst_busy", 32'(busy_f), 32'h0);
        check("rw_rst_done", 32'(done_f), 32'h0);
        check("rw_rst_rdata", rdata_f, 32'h0);
        rst = 1'b0;
        tick(3);
        check("rw_no_done", 32'(done_f), 32'h0);
        set_ch(1, 1'b1, 2'd0, 32'h500, 32'h77);
        req_f = 2'b10;
        tick();
        check("rw_new_a", mem_a_f, 32'h500);
        check("rw_new_d", 32'(mem_dout_f), 32'h77);
        check("rw_new_w", 32'(mem_wr_f), 32'h1);
        tick();
        check("rw_new_done", 32'(done_f), 32'h2);
        req_f = 2'b00;
        tick();

        // Round robin: serve ch0 alone, then both continuously -> 1,0,1,0
        set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
        set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0);
        req_r = 2'b01;
        tick(3);
        check("rr_solo_done", 32'(done_r), 32'h1);
        check("rr_solo_data", rdata_r, 32'h11);
        req_r = 2'b00;
        tick();
        req_r = 2'b11;
        for (int s = 1; s <= 12; s++) begin
            tick();
            if (s % 3 == 1)
                check("rr_addr", mem_a_r, ((s / 3) % 2 == 0) ? 32'h101 : 32'h100);
            if (s % 3 == 0) begin
                check("rr_done", 32'(done_r), ((s / 3) % 2 == 1) ? 32'h2 : 32'h1);
                check("rr_data", rdata_r, ((s / 3) % 2 == 1) ? 32'h22 : 32'h11);
            end
        end
        req_r = 2'b00;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
